// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO width-conversion types and ratio/lane-width helpers
package fifo_pkg;

    // Widest lane index any packer/unpacker instance may use.
    localparam int MAX_LANE_W = 8;

    // Lane index in its widest form; narrower per-instance lane registers are cast to it for comparisons.
    typedef logic [MAX_LANE_W-1:0] lane_idx_t;

    // Number of narrow beats that make up one FIFO word.
    function automatic int calc_ratio(input int data_width, input int in_width);
        return data_width / in_width;
    endfunction

    // Bits needed to index a lane; never less than one so the lane register always exists.
    function automatic int calc_lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_packer_if.sv
// rtl/fifo_wr_packer_if.sv - byte-stream input and FIFO write-port bundle for the write-side packer
interface fifo_wr_packer_if #(
    parameter int IN_WIDTH   = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [IN_WIDTH-1:0]   in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;

    // Upstream source plus FIFO side, as seen from outside the packer.
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output fifo_full,
        input  in_ready,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

    // The packer itself.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  fifo_full,
        output in_ready,
        output fifo_wr_en,
        output fifo_wr_data
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter in the write clock domain
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    // Count qualifying edges, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_wr_packer.sv
// rtl/fifo_wr_packer.sv - packs narrow beats into little-endian FIFO words; stats via FIFO_WR_PACKER_STATS_EN
module fifo_wr_packer
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr,
    fifo_wr_packer_if.slave      bus,
    output logic [CNT_WIDTH-1:0] words_written,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam int RATIO  = calc_ratio(DATA_WIDTH, IN_WIDTH);
    localparam int LANE_W = calc_lane_w(RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    generate
        if ((DATA_WIDTH % IN_WIDTH) != 0 || RATIO < 2 || LANE_W > MAX_LANE_W) begin : g_bad_cfg
            $error("fifo_wr_packer: DATA_WIDTH must be a multiple of IN_WIDTH with at least two lanes");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] out_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [LANE_W-1:0]     lane;
    logic                  out_valid;
    logic                  lane_last;
    logic                  blocked;
    logic                  accept;
    logic                  complete;
    logic                  wr_en;

    assign lane_last = (lane == LAST_LANE);
    // A held word that the FIFO cannot take blocks only beats that would need to replace it.
    assign blocked   = out_valid && bus.fifo_full;
    assign bus.in_ready = !blocked || (!lane_last && !bus.in_last);
    assign accept    = bus.in_valid && bus.in_ready;
    assign complete  = accept && (lane_last || bus.in_last);
    assign wr_en     = out_valid && !bus.fifo_full;

    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_data = out_word;

    // Accumulator with the current beat dropped into its lane and every lane above it cleared.
    always_comb begin
        merged = acc;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_idx_t'(i) == lane_idx_t'(lane)) begin
                merged[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
            end else if (lane_idx_t'(i) > lane_idx_t'(lane)) begin
                merged[i*IN_WIDTH +: IN_WIDTH] = '0;
            end
        end
    end

    // Assemble beats; a completing beat hands the word to the output register and restarts at lane 0.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            acc      <= '0;
            lane     <= '0;
            out_word <= '0;
        end else if (complete) begin
            out_word <= merged;
            acc      <= '0;
            lane     <= '0;
        end else if (accept) begin
            acc      <= merged;
            lane     <= lane + LANE_W'(1);
        end
    end

    // Output word is pending from completion until the FIFO takes it; a same-cycle reload keeps it set.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            out_valid <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
        end else if (wr_en) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FIFO_WR_PACKER_STATS_EN
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_words_written (
        .clk_wr (clk_wr),
        .rst_wr (rst_wr),
        .inc    (wr_en),
        .count  (words_written)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cycles (
        .clk_wr (clk_wr),
        .rst_wr (rst_wr),
        .inc    (blocked),
        .count  (stall_cycles)
    );
`else
    assign words_written = '0;
    assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb/tb_fifo_wr_packer.sv - self-checking bench for fifo_wr_packer
module tb_fifo_wr_packer;

    localparam int IW    = 8;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int RATIO = DW / IW;

    logic          clk_wr = 1'b0;
    logic          rst_wr;
    logic [CW-1:0] words_written;
    logic [CW-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    fifo_wr_packer_if #(.IN_WIDTH(IW), .DATA_WIDTH(DW)) bus();

    fifo_wr_packer #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_wr        (clk_wr),
        .rst_wr        (rst_wr),
        .bus           (bus),
        .words_written (words_written),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk_wr = ~clk_wr;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        f;
        logic        er;
        logic        ew;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [11];

`ifdef FIFO_WR_PACKER_STATS_EN
    function automatic logic [CW-1:0] exp_cnt(input int n);
        return CW'(n);
    endfunction
`else
    function automatic logic [CW-1:0] exp_cnt(input int n);
        return (n < 0) ? '1 : '0;
    endfunction
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle at posedge+1, check combinational outputs before the next edge, then clock.
    task automatic apply(input logic v, input logic [7:0] d, input logic l, input logic f,
                         input logic er, input logic ew, input logic [31:0] ed, input string tag);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.fifo_full = f;
        #1;
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'(er));
        check({tag, " wr_en"}, 32'(bus.fifo_wr_en), 32'(ew));
        if (ew) check({tag, " wr_data"}, bus.fifo_wr_data, ed);
        @(posedge clk_wr);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.fifo_full = 1'b0;
        rst_wr = 1'b1;
        @(posedge clk_wr);
        #1;
        rst_wr = 1'b0;
    endtask

    function automatic logic [31:0] pack(input logic [7:0] q [$]);
        logic [31:0] w;
        w = '0;
        foreach (q[i]) w[8*i +: 8] = q[i];
        return w;
    endfunction

    function automatic logic [7:0] ob(input int k);
        return 8'(16 * k + 3);
    endfunction

    logic [7:0]  cur [$];
    logic        hold_v;
    logic [31:0] hold_w;
    int          m_words;
    int          m_stalls;

    initial begin
        logic v, l, f, er, ew, pv, prdy;
        logic [7:0] d;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.fifo_full = 1'b0;
        rst_wr = 1'b1;
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("reset wr_data", bus.fifo_wr_data, 32'd0);
        check("reset words_written", 32'(words_written), 32'd0);
        check("reset stall_cycles", 32'(stall_cycles), 32'd0);

        // Basic packing, partial flush, lane-0 flush.
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211};
        tbl[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000BBAA};
        tbl[8]  = '{1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000CC};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f, tbl[i].er, tbl[i].ew, tbl[i].ed,
                  $sformatf("vec%0d", i));
        end

        // Back-pressure: eight beats against a full FIFO, then release.
        do_reset();
        for (int i = 1; i <= 7; i++) apply(1'b1, 8'(i), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, $sformatf("bp beat%0d", i));
        apply(1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "bp beat8 hold");
        apply(1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "bp beat8 hold2");
        apply(1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, "bp release1");
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h08070605, "bp release2");
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "bp idle");
        check("bp stall_cycles", 32'(stall_cycles), 32'(exp_cnt(5)));
        check("bp words_written", 32'(words_written), 32'(exp_cnt(2)));

        // Continuous 16-beat stream: drain and completion overlap every fourth cycle.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            int g;
            g = k / 4 - 1;
            apply(1'b1, ob(k), 1'b0, 1'b0, 1'b1, (k >= 4 && k % 4 == 0),
                  {ob(4*g+3), ob(4*g+2), ob(4*g+1), ob(4*g)}, $sformatf("ovl beat%0d", k));
        end
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, {ob(15), ob(14), ob(13), ob(12)}, "ovl tail");
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "ovl idle");
        check("ovl words_written", 32'(words_written), 32'(exp_cnt(4)));

        // Mid-frame reset with a word pending behind a full FIFO.
        do_reset();
        for (int i = 1; i <= 6; i++) apply(1'b1, 8'(16 * i), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, $sformatf("mr beat%0d", i));
        bus.in_valid  = 1'b0;
        bus.fifo_full = 1'b0;
        rst_wr = 1'b1;
        #1;
        check("mr wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("mr wr_data", bus.fifo_wr_data, 32'd0);
        check("mr in_ready", 32'(bus.in_ready), 32'd1);
        check("mr stall_cycles", 32'(stall_cycles), 32'd0);
        #2;
        rst_wr = 1'b0;
        @(posedge clk_wr);
        #1;
        for (int i = 1; i <= 4; i++) apply(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, $sformatf("mr post%0d", i));
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, "mr word");
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "mr idle");

        // Random traffic against a queue-based model of the packing rules.
        do_reset();
        cur.delete();
        hold_v = 1'b0;
        hold_w = '0;
        m_words = 0;
        m_stalls = 0;
        pv = 1'b0;
        prdy = 1'b1;
        v = 1'b0;
        d = '0;
        l = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(pv && !prdy)) begin
                v = ($urandom % 4) != 0;
                d = 8'($urandom);
                l = ($urandom % 6) == 0;
            end
            f  = ($urandom % 3) == 0;
            er = !(hold_v && f) || ((cur.size() != RATIO - 1) && !l);
            ew = hold_v && !f;
            apply(v, d, l, f, er, ew, hold_w, $sformatf("rand%0d", n));
            if (hold_v && f) m_stalls++;
            if (ew) begin
                m_words++;
                hold_v = 1'b0;
            end
            if (v && er) begin
                cur.push_back(d);
                if (cur.size() == RATIO || l) begin
                    hold_w = pack(cur);
                    hold_v = 1'b1;
                    cur.delete();
                end
            end
            pv = v;
            prdy = er;
        end
        check("rand words_written", 32'(words_written), 32'(exp_cnt(m_words)));
        check("rand stall_cycles", 32'(stall_cycles), 32'(exp_cnt(m_stalls)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
